// File: rtl/eq_gain_scheduler.sv
// eq_gain_scheduler: per-band target/applied gain store. Gain-set requests update
// the target immediately; changed bands are pushed to the DSP coefficient port
// only in the pass that follows a sample-frame pulse.
// Optional macro GAIN_RAMP_EN: each write moves the applied gain one step toward
// the target instead of jumping straight to it.
module eq_gain_scheduler #(
    parameter int NBAND = 7,
    parameter int GW    = 16,
    parameter int GMAX  = 12,
    parameter int GMIN  = -12
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_req,
    input  logic [2:0]           i_band,
    input  logic signed [GW-1:0] i_gain,
    output logic                 o_req_err,
    input  logic                 i_frame,
    output logic                 o_wr_en,
    output logic [2:0]           o_wr_band,
    output logic signed [GW-1:0] o_wr_gain,
    input  logic                 i_wr_ready,
    output logic [NBAND-1:0]     o_dirty,
    output logic                 o_busy,
    output logic                 o_overrun,
    input  logic [2:0]           i_rd_band,
    output logic signed [GW-1:0] o_rd_gain
);

    localparam logic [3:0]           NB4    = 4'(NBAND);
    localparam logic [2:0]           LAST   = 3'(NBAND - 1);
    localparam logic signed [GW-1:0] GMAX_W = GW'(GMAX);
    localparam logic signed [GW-1:0] GMIN_W = GW'(GMIN);
    localparam logic signed [GW-1:0] ONE_W  = GW'(1);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_WRITE} state_t;

    state_t                r_state, w_state_nxt;
    logic [2:0]            r_ptr, w_ptr_nxt;
    logic                  r_wr_en, w_wr_en_nxt;
    logic [2:0]            r_wr_band, w_wr_band_nxt;
    logic signed [GW-1:0]  r_wr_gain, w_wr_gain_nxt;
    logic                  w_commit;

    logic signed [GW-1:0]  r_tgt [NBAND];
    logic signed [GW-1:0]  r_cur [NBAND];
    logic                  r_req_err;
    logic                  r_overrun;
    logic signed [GW-1:0]  r_rd_gain;

    logic                  w_band_ok;
    logic                  w_req_ok;
    logic signed [GW-1:0]  w_clamped;
    logic signed [GW-1:0]  w_next_gain;

    assign w_band_ok = ({1'b0, i_band} < NB4);
    assign w_req_ok  = i_req && w_band_ok;

    // Signed clamp of the requested gain into [GMIN, GMAX]
    always_comb begin
        w_clamped = i_gain;
        if (i_gain > GMAX_W)
            w_clamped = GMAX_W;
        else if (i_gain < GMIN_W)
            w_clamped = GMIN_W;
    end

    // Dirty vector: target and applied gain differ
    always_comb begin
        o_dirty = '0;
        for (int unsigned b = 0; b < NBAND; b++)
            o_dirty[b] = (r_tgt[b] != r_cur[b]);
    end

    // Value to write for the band under the pointer
    always_comb begin
`ifdef GAIN_RAMP_EN
        if (r_tgt[r_ptr] > r_cur[r_ptr])
            w_next_gain = r_cur[r_ptr] + ONE_W;
        else
            w_next_gain = r_cur[r_ptr] - ONE_W;
`else
        w_next_gain = r_tgt[r_ptr];
`endif
    end

    // Next-state logic for the frame pass and the write port
    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_wr_en_nxt   = r_wr_en;
        w_wr_band_nxt = r_wr_band;
        w_wr_gain_nxt = r_wr_gain;
        w_commit      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_frame && (|o_dirty)) begin
                    w_ptr_nxt   = '0;
                    w_state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                if (o_dirty[r_ptr]) begin
                    w_wr_en_nxt   = 1'b1;
                    w_wr_band_nxt = r_ptr;
                    w_wr_gain_nxt = w_next_gain;
                    w_state_nxt   = S_WRITE;
                end else if (r_ptr == LAST) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_ptr_nxt = r_ptr + 3'd1;
                end
            end
            S_WRITE: begin
                if (r_wr_en && i_wr_ready) begin
                    w_commit    = 1'b1;
                    w_wr_en_nxt = 1'b0;
                    if (r_ptr == LAST) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_ptr_nxt   = r_ptr + 3'd1;
                        w_state_nxt = S_SCAN;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM state, pointer and write-port registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_wr_en   <= 1'b0;
            r_wr_band <= '0;
            r_wr_gain <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_wr_en   <= w_wr_en_nxt;
            r_wr_band <= w_wr_band_nxt;
            r_wr_gain <= w_wr_gain_nxt;
        end
    end

    // Gain storage: targets from requests, applied gains from accepted writes
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int unsigned b = 0; b < NBAND; b++) begin
                r_tgt[b] <= '0;
                r_cur[b] <= '0;
            end
        end else begin
            if (w_req_ok)
                r_tgt[i_band] <= w_clamped;
            if (w_commit)
                r_cur[r_ptr] <= r_wr_gain;
        end
    end

    // Status pulses and registered readback
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_req_err <= 1'b0;
            r_overrun <= 1'b0;
            r_rd_gain <= '0;
        end else begin
            r_req_err <= i_req && !w_band_ok;
            r_overrun <= i_frame && (r_state != S_IDLE);
            r_rd_gain <= ({1'b0, i_rd_band} < NB4) ? r_cur[i_rd_band] : '0;
        end
    end

    assign o_wr_en   = r_wr_en;
    assign o_wr_band = r_wr_band;
    assign o_wr_gain = r_wr_gain;
    assign o_busy    = (r_state != S_IDLE);
    assign o_req_err = r_req_err;
    assign o_overrun = r_overrun;
    assign o_rd_gain = r_rd_gain;

endmodule

// File: tb/tb_eq_gain_scheduler.sv
// Self-checking bench for eq_gain_scheduler: directed steps plus randomized
// request/frame rounds against a behavioural gain model.
module tb_eq_gain_scheduler;

    localparam int NB   = 7;
    localparam int GW   = 16;
    localparam int GMAX = 12;
    localparam int GMIN = -12;

    logic          clk = 1'b0;
    logic          i_rst, i_req, i_frame, i_wr_ready;
    logic [2:0]    i_band, i_rd_band;
    logic [GW-1:0] i_gain;
    logic          o_req_err, o_wr_en, o_busy, o_overrun;
    logic [2:0]    o_wr_band;
    logic [GW-1:0] o_wr_gain, o_rd_gain;
    logic [NB-1:0] o_dirty;

    int n_tests = 0;
    int n_fail  = 0;
    int m_tgt [NB];
    int m_cur [NB];

    always #5 clk = ~clk;

    eq_gain_scheduler #(.NBAND(NB), .GW(GW), .GMAX(GMAX), .GMIN(GMIN)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_req(i_req), .i_band(i_band), .i_gain(i_gain),
        .o_req_err(o_req_err), .i_frame(i_frame), .o_wr_en(o_wr_en),
        .o_wr_band(o_wr_band), .o_wr_gain(o_wr_gain), .i_wr_ready(i_wr_ready),
        .o_dirty(o_dirty), .o_busy(o_busy), .o_overrun(o_overrun),
        .i_rd_band(i_rd_band), .o_rd_gain(o_rd_gain)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int clampi(input int g);
        if (g > GMAX) return GMAX;
        if (g < GMIN) return GMIN;
        return g;
    endfunction

    function automatic int mnext(input int b);
`ifdef GAIN_RAMP_EN
        return (m_tgt[b] > m_cur[b]) ? m_cur[b] + 1 : m_cur[b] - 1;
`else
        return m_tgt[b];
`endif
    endfunction

    function automatic logic [NB-1:0] mdirty();
        logic [NB-1:0] d;
        for (int b = 0; b < NB; b++) d[b] = (m_tgt[b] != m_cur[b]);
        return d;
    endfunction

    task automatic model_reset();
        for (int b = 0; b < NB; b++) begin
            m_tgt[b] = 0;
            m_cur[b] = 0;
        end
    endtask

    task automatic do_req(input int band, input int gain);
        i_req  = 1'b1;
        i_band = band[2:0];
        i_gain = gain[GW-1:0];
        tick();
        i_req = 1'b0;
        if (band < NB) m_tgt[band] = clampi(gain);
        check("req_err", o_req_err, band >= NB);
        check("req_dirty", o_dirty, mdirty());
        tick();
        check("req_err_clear", o_req_err, 0);
    endtask

    task automatic readback_all();
        logic [GW-1:0] e;
        for (int b = 0; b < 8; b++) begin
            i_rd_band = 3'(b);
            tick();
            e = (b < NB) ? 16'(m_cur[b]) : 16'd0;
            check("rd_gain", o_rd_gain, e);
        end
    endtask

    // mode 0: ready high, 1: random ready, 2: ready held low 4 cycles per write
    task automatic run_frame(input int mode, input int ovr_at);
        int            eb[$];
        int            eg[$];
        int            nw, cyc, stall;
        bit            pend, ovr_exp;
        logic [2:0]    pb;
        logic [GW-1:0] pg, eg16;
        for (int b = 0; b < NB; b++) begin
            if (m_tgt[b] != m_cur[b]) begin
                eb.push_back(b);
                eg.push_back(mnext(b));
            end
        end
        nw = 0; cyc = 0; stall = 0; pend = 0; pb = '0; pg = '0;
        i_frame = 1'b1;
        tick();
        i_frame = 1'b0;
        check("frame_busy", o_busy, eb.size() != 0);
        check("overrun_idle", o_overrun, 0);
        while (o_busy && cyc < 200) begin
            case (mode)
                0:       i_wr_ready = 1'b1;
                1:       i_wr_ready = 1'($urandom_range(0, 1));
                default: i_wr_ready = o_wr_en && (stall >= 4);
            endcase
            if (pend) begin
                check("hold_en", o_wr_en, 1);
                check("hold_band", o_wr_band, pb);
                check("hold_gain", o_wr_gain, pg);
            end
            if (o_wr_en) begin
                if (i_wr_ready) begin
                    if (nw < eb.size()) begin
                        eg16 = 16'(eg[nw]);
                        check("wr_band", o_wr_band, eb[nw]);
                        check("wr_gain", o_wr_gain, eg16);
                    end else begin
                        check("excess_write", nw + 1, eb.size());
                    end
                    nw++;
                    pend  = 0;
                    stall = 0;
                end else begin
                    pend = 1;
                    pb   = o_wr_band;
                    pg   = o_wr_gain;
                    stall++;
                end
            end
            if (cyc == ovr_at) i_frame = 1'b1;
            ovr_exp = i_frame;
            tick();
            i_frame = 1'b0;
            cyc++;
            check("overrun", o_overrun, ovr_exp);
        end
        check("pass_done", o_busy, 0);
        check("write_count", nw, eb.size());
        for (int k = 0; k < eb.size(); k++) m_cur[eb[k]] = eg[k];
        check("dirty_after", o_dirty, mdirty());
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        i_rst = 1'b1; i_req = 1'b0; i_band = '0; i_gain = '0;
        i_frame = 1'b0; i_wr_ready = 1'b0; i_rd_band = '0;
        model_reset();
        repeat (3) tick();
        check("rst_wr_en", o_wr_en, 0);
        check("rst_wr_band", o_wr_band, 0);
        check("rst_wr_gain", o_wr_gain, 0);
        check("rst_busy", o_busy, 0);
        check("rst_dirty", o_dirty, 0);
        check("rst_req_err", o_req_err, 0);
        check("rst_overrun", o_overrun, 0);
        check("rst_rd_gain", o_rd_gain, 0);
        i_rst = 1'b0;
        tick();

        // Clean frame: nothing to write
        run_frame(0, -1);
        readback_all();

        // Clamp high, then single write of band 3
        do_req(3, 20);
        run_frame(0, -1);
        readback_all();

        // Invalid band and low clamp
        do_req(7, 5);
        do_req(0, -30);
        run_frame(0, -1);
        readback_all();

        // Two dirty bands with stalled handshake and an overrun frame mid-write
        do_req(1, 7);
        do_req(5, -4);
        run_frame(2, 3);
        readback_all();

        // Randomized rounds
        repeat (15) begin
            repeat ($urandom_range(1, 4))
                do_req(int'($urandom_range(0, 7)), int'($urandom_range(0, 80)) - 40);
            run_frame(int'($urandom_range(0, 2)), int'($urandom_range(0, 12)));
            readback_all();
        end

        // Reset while a write is pending
        do_req(2, 9);
        do_req(6, -9);
        i_wr_ready = 1'b0;
        i_frame = 1'b1;
        tick();
        i_frame = 1'b0;
        cyc = 0;
        while (!o_wr_en && cyc < 20) begin
            tick();
            cyc++;
        end
        check("reach_write", o_wr_en, 1);
        i_rst = 1'b1;
        tick();
        check("midrst_wr_en", o_wr_en, 0);
        check("midrst_busy", o_busy, 0);
        check("midrst_dirty", o_dirty, 0);
        i_rst = 1'b0;
        model_reset();
        readback_all();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
